// File: rtl/vdp_sync_decoder_if.sv
// vdp_sync_decoder_if: sync inputs and recovered timing outputs of the VDP sync decoder
interface vdp_sync_decoder_if;
  logic        hsync_in;
  logic        vsync_n_in;
  logic [10:0] line_len;
  logic [9:0]  lines_per_field;
  logic [10:0] rec_h_cnt;
  logic [9:0]  rec_v_cnt;
  logic        locked;
  logic        pal_detect;
  logic        interlace_detect;
  logic        field_parity;
  logic        timing_err;
  modport master (
    output hsync_in, vsync_n_in,
    input  line_len, lines_per_field, rec_h_cnt, rec_v_cnt, locked,
           pal_detect, interlace_detect, field_parity, timing_err
  );
  modport slave (
    input  hsync_in, vsync_n_in,
    output line_len, lines_per_field, rec_h_cnt, rec_v_cnt, locked,
           pal_detect, interlace_detect, field_parity, timing_err
  );
endinterface

// File: rtl/vdp_sync_decoder.sv
// vdp_sync_decoder: measures hsync/vsync timing, locks on stable lines, recovers h/v position
module vdp_sync_decoder #(
  parameter int LOCK_LINES = 4,
  parameter int PAL_THRESH = 288,
  parameter int H_TIMEOUT  = 2047
) (
  input logic               clk21m,
  input logic               reset,
  vdp_sync_decoder_if.slave bus
);
  localparam int MW = $clog2(LOCK_LINES) + 1;
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_e;
  state_e        state_q, state_d;
  logic          hs1_q, hs2_q, vs1_q, vs2_q;
  logic [10:0]   hcnt_q, line_len_q, ref_q, ref_d, period;
  logic [9:0]    vcnt_q, lpf_q, lines;
  logic [MW-1:0] match_q, match_d;
  logic          ref_vld_q, ref_vld_d, field_q, il_q, fp_q, pal_q, err_q, err_d;
  logic          hs_edge, vs_edge, timeout;
  assign hs_edge = hs1_q & ~hs2_q;
  assign vs_edge = ~vs1_q & vs2_q;
  assign timeout = ~hs_edge && hcnt_q == 11'(H_TIMEOUT - 1);
  assign period  = hcnt_q + 11'd1;
  assign lines   = (vcnt_q == 10'd1023) ? vcnt_q : vcnt_q + 10'd1;
  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    ref_d     = ref_q;
    ref_vld_d = ref_vld_q;
    err_d     = 1'b0;
    if (timeout) begin
      state_d = UNLOCKED;
      err_d   = 1'b1;
    end else if (hs_edge) begin
      if (state_q == UNLOCKED) begin
        state_d   = ACQUIRE;
        match_d   = '0;
        ref_vld_d = 1'b0;
      end else if (state_q == ACQUIRE) begin
        if (ref_vld_q && period == ref_q) begin
          match_d = match_q + 1'b1;
          state_d = (match_d == MW'(LOCK_LINES - 1)) ? LOCKED : ACQUIRE;
        end else begin
          ref_d     = period;
          ref_vld_d = 1'b1;
          match_d   = '0;
        end
      end else if (period != line_len_q) begin
        state_d = UNLOCKED;
        err_d   = 1'b1;
      end
    end
  end
  always_ff @(posedge clk21m) begin
    if (reset) begin
      state_q    <= UNLOCKED;
      hs1_q      <= 1'b0;
      hs2_q      <= 1'b0;
      vs1_q      <= 1'b1;
      vs2_q      <= 1'b1;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      line_len_q <= '0;
      lpf_q      <= '0;
      ref_q      <= '0;
      ref_vld_q  <= 1'b0;
      match_q    <= '0;
      field_q    <= 1'b0;
      il_q       <= 1'b0;
      fp_q       <= 1'b0;
      pal_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hs1_q     <= bus.hsync_in;
      hs2_q     <= hs1_q;
      vs1_q     <= bus.vsync_n_in;
      vs2_q     <= vs1_q;
      hcnt_q    <= hs_edge ? 11'd0 : (hcnt_q == 11'(H_TIMEOUT)) ? hcnt_q : hcnt_q + 11'd1;
      vcnt_q    <= vs_edge ? 10'd0 : (hs_edge && vcnt_q != 10'd1023) ? vcnt_q + 10'd1 : vcnt_q;
      ref_q     <= ref_d;
      ref_vld_q <= ref_vld_d;
      match_q   <= match_d;
      err_q     <= err_d;
      if (hs_edge) line_len_q <= period;
      // the first vsync only opens the measurement window
      if (vs_edge) begin
        field_q <= 1'b1;
        if (field_q) begin
          lpf_q <= lines;
          il_q  <= ({1'b0, lines} + 11'd1 == {1'b0, lpf_q}) || ({1'b0, lpf_q} + 11'd1 == {1'b0, lines});
          fp_q  <= lines > lpf_q;
          pal_q <= lines >= 10'(PAL_THRESH);
        end
      end
    end
  end
  assign bus.locked           = state_q == LOCKED;
  assign bus.line_len         = line_len_q;
  assign bus.lines_per_field  = lpf_q;
  assign bus.rec_h_cnt        = bus.locked ? hcnt_q : '0;
  assign bus.rec_v_cnt        = bus.locked ? vcnt_q : '0;
  assign bus.pal_detect       = pal_q;
  assign bus.interlace_detect = il_q;
  assign bus.field_parity     = fp_q;
  assign bus.timing_err       = err_q;
endmodule

// File: tb/tb_vdp_sync_decoder.sv
// tb_vdp_sync_decoder: event-level timing model compared every cycle, plus literal scenario checks
module tb_vdp_sync_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;
  vdp_sync_decoder_if ifc();
  vdp_sync_decoder dut (.clk21m(clk), .reset(rst), .bus(ifc.slave));
  always #5 clk = ~clk;
  bit m_valid = 1'b0;
  bit mh1, mh2, mv1, mv2, he, ve, seen, have_ref, m_il, m_fp, m_pal, m_err;
  int since, vlines, vold, m_ll, m_lpf, p, n, mode, run, ref_len;
  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask
  // model: lines are distances between hsync rises; lock = 4 equal distances after arming
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      mh1 = 1'b0; mh2 = 1'b0; mv1 = 1'b1; mv2 = 1'b1;
      since = 0; vlines = 0; seen = 1'b0; m_ll = 0; m_lpf = 0;
      m_il = 1'b0; m_fp = 1'b0; m_pal = 1'b0; m_err = 1'b0;
      mode = 0; run = 0; have_ref = 1'b0; ref_len = 0;
    end else begin
      he = mh1 && !mh2;
      ve = !mv1 && mv2;
      mh2 = mh1; mh1 = ifc.hsync_in; mv2 = mv1; mv1 = ifc.vsync_n_in;
      m_err = 1'b0;
      vold = vlines;
      if (he) begin
        p = (since < 2047) ? since + 1 : 0;
        if (mode == 0) begin
          mode = 1; run = 0; have_ref = 1'b0;
        end else if (mode == 1) begin
          if (have_ref && p == ref_len) begin
            run++;
            if (run == 3) mode = 2;
          end else begin
            ref_len = p; have_ref = 1'b1; run = 0;
          end
        end else if (p != m_ll) begin
          mode = 0; m_err = 1'b1;
        end
        m_ll = p;
        since = 0;
        if (vlines < 1023) vlines++;
      end else begin
        since++;
        if (since == 2047) begin
          mode = 0; m_err = 1'b1;
        end
      end
      if (ve) begin
        n = (vold < 1023) ? vold + 1 : 1023;
        if (seen) begin
          m_il = (n - m_lpf == 1) || (m_lpf - n == 1);
          m_fp = n > m_lpf;
          m_pal = n >= 288;
          m_lpf = n;
        end
        seen = 1'b1;
        vlines = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (m_valid) begin
      if (ifc.timing_err) err_seen++;
      chk("line_len", int'(ifc.line_len), m_ll);
      chk("lines_per_field", int'(ifc.lines_per_field), m_lpf);
      chk("rec_h_cnt", int'(ifc.rec_h_cnt), mode == 2 ? (since > 2047 ? 2047 : since) : 0);
      chk("rec_v_cnt", int'(ifc.rec_v_cnt), mode == 2 ? vlines : 0);
      chk("locked", int'(ifc.locked), int'(mode == 2));
      chk("pal_detect", int'(ifc.pal_detect), int'(m_pal));
      chk("interlace_detect", int'(ifc.interlace_detect), int'(m_il));
      chk("field_parity", int'(ifc.field_parity), int'(m_fp));
      chk("timing_err", int'(ifc.timing_err), int'(m_err));
    end
  end
  task automatic line(int c0, int c1, int hw, bit vlow);
    for (int c = c0; c < c1; c++) begin
      @(negedge clk);
      ifc.hsync_in   = (c < hw);
      ifc.vsync_n_in = !vlow;
    end
  endtask
  task automatic field(int nl);
    for (int l = 0; l < nl; l++) line(0, 24, 4, l < 3);
  endtask
  initial begin
    int len;
    ifc.hsync_in = 1'b0;
    ifc.vsync_n_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_line_len", int'(ifc.line_len), 0);
    chk("rst_locked", int'(ifc.locked), 0);
    repeat (6) line(0, 1368, 100, 1'b0);
    chk("lock_locked", int'(ifc.locked), 1);
    chk("lock_line_len", int'(ifc.line_len), 1368);
    line(0, 1369, 100, 1'b0);
    line(0, 1368, 100, 1'b0);
    chk("jitter_err_pulses", err_seen, 1);
    chk("jitter_unlocked", int'(ifc.locked), 0);
    repeat (6) line(0, 1368, 100, 1'b0);
    chk("jitter_relock", int'(ifc.locked), 1);
    repeat (2100) @(negedge clk) ifc.hsync_in = 1'b0;
    chk("timeout_err_pulses", err_seen, 2);
    chk("timeout_locked", int'(ifc.locked), 0);
    chk("timeout_rec_h", int'(ifc.rec_h_cnt), 0);
    chk("timeout_rec_v", int'(ifc.rec_v_cnt), 0);
    chk("no_field_yet", int'(ifc.lines_per_field), 0);
    field(262); field(262);
    chk("ntsc_lpf", int'(ifc.lines_per_field), 262);
    chk("ntsc_pal", int'(ifc.pal_detect), 0);
    chk("ntsc_il", int'(ifc.interlace_detect), 0);
    field(313); field(262);
    chk("pal_lpf", int'(ifc.lines_per_field), 313);
    chk("pal_pal", int'(ifc.pal_detect), 1);
    field(263); field(262);
    chk("il_lpf", int'(ifc.lines_per_field), 263);
    chk("il_detect_a", int'(ifc.interlace_detect), 1);
    chk("il_parity_a", int'(ifc.field_parity), 1);
    field(263);
    chk("il_detect_b", int'(ifc.interlace_detect), 1);
    chk("il_parity_b", int'(ifc.field_parity), 0);
    line(0, 10, 4, 1'b1);
    chk("newfield_rec_v", int'(ifc.rec_v_cnt), 0);
    chk("newfield_locked", int'(ifc.locked), 1);
    line(10, 24, 4, 1'b1);
    field(40);
    line(0, 12, 4, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_line_len", int'(ifc.line_len), 0);
    chk("midrst_lpf", int'(ifc.lines_per_field), 0);
    chk("midrst_locked", int'(ifc.locked), 0);
    chk("midrst_err", int'(ifc.timing_err), 0);
    rst = 1'b0;
    repeat (8) line(0, 24, 4, 1'b0);
    chk("midrst_relock", int'(ifc.locked), 1);
    repeat (300) begin
      len = ($urandom % 4 == 0) ? 18 + int'($urandom % 16) : 24;
      line(0, len, 1 + int'($urandom % (len - 1)), ($urandom % 30) == 0);
    end
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
